// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory interface: the mem_if state
// enumeration and the default datapath/address width.
package cpu_pkg;

   localparam int MEM_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_t;

endpackage : cpu_pkg

// File: rtl/mem_if_timer.sv
// Access-cycle counter for mem_if. Counts cycles while enabled, returns to
// zero when cleared, and flags expiry on the TIMEOUT-th enabled cycle so the
// controller can abort on that same edge. Only instantiated when
// MEM_TIMEOUT_EN is defined.
module mem_if_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   // Cycle counter: zeroed by reset or clear, advances once per enabled cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {CW{1'b0}};
      end else if (clear) begin
         count <= {CW{1'b0}};
      end else if (enable) begin
         count <= count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

   // The count starts at zero on the first enabled cycle, so TIMEOUT-1 marks
   // the last cycle allowed before the abort takes effect.
   assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule : mem_if_timer

// File: rtl/mem_if.sv
// mem_if: CPU-side memory interface holding the MAR/MDR registers and a
// three-state handshake controller (IDLE -> ACCESS -> DONE).
// Optional feature macro: MEM_TIMEOUT_EN -- when defined, an access that
// sees no memAck for TIMEOUT cycles is aborted with done and err pulsed.
// When undefined, ACCESS waits indefinitely and err is tied low.
module mem_if
   import cpu_pkg::*;
#(
   parameter int WIDTH   = MEM_WIDTH_DEFAULT,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             marEn,
   input  logic             mdrEn,
   input  logic             rd,
   input  logic             wr,
   input  logic [WIDTH-1:0] busIn,
   output logic [WIDTH-1:0] mdrOut,
   output logic [WIDTH-1:0] memAddr,
   output logic [WIDTH-1:0] memWdata,
   input  logic [WIDTH-1:0] memRdata,
   output logic             memReq,
   output logic             memWe,
   input  logic             memAck,
   output logic             busy,
   output logic             done,
   output logic             err
);

   mem_state_t       state_r, state_nxt;
   logic [WIDTH-1:0] mar_r, mdr_r;
   logic             req_r, req_nxt;
   logic             we_r, we_nxt;
   logic             busy_r, busy_nxt;
   logic             done_r, done_nxt;
   logic             err_r, err_nxt;
   logic             in_idle_s, in_access_s;

   assign in_idle_s   = (state_r == ST_IDLE);
   assign in_access_s = (state_r == ST_ACCESS);

`ifdef MEM_TIMEOUT_EN
   logic timer_expired_s;

   mem_if_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (~in_access_s),
      .enable  (in_access_s),
      .expired (timer_expired_s)
   );
`endif

   // Next-state and next-output decode; outputs are registered alongside the
   // state so they describe the state being entered.
   always_comb begin
      state_nxt = state_r;
      req_nxt   = 1'b0;
      we_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd || wr) begin
               // rd wins when both are requested.
               state_nxt = ST_ACCESS;
               req_nxt   = 1'b1;
               we_nxt    = wr & ~rd;
               busy_nxt  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (memAck) begin
               state_nxt = ST_DONE;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (timer_expired_s) begin
               state_nxt = ST_DONE;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
            end
`endif
            else begin
               state_nxt = ST_ACCESS;
               req_nxt   = 1'b1;
               we_nxt    = we_r;
               busy_nxt  = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and handshake output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt;
         req_r   <= req_nxt;
         we_r    <= we_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
         err_r   <= err_nxt;
      end
   end

   // MAR: loaded from the datapath only while idle, frozen during an access.
   always_ff @(posedge clk) begin
      if (reset) begin
         mar_r <= {WIDTH{1'b0}};
      end else if (in_idle_s && marEn) begin
         mar_r <= busIn;
      end else begin
         mar_r <= mar_r;
      end
   end

   // MDR: loaded from the datapath while idle, or captured from memory on
   // the acknowledge edge of a read. Writes and timeouts leave it untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdr_r <= {WIDTH{1'b0}};
      end else if (in_idle_s && mdrEn) begin
         mdr_r <= busIn;
      end else if (in_access_s && memAck && !we_r) begin
         mdr_r <= memRdata;
      end else begin
         mdr_r <= mdr_r;
      end
   end

   assign memAddr  = mar_r;
   assign memWdata = mdr_r;
   assign mdrOut   = mdr_r;
   assign memReq   = req_r;
   assign memWe    = we_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule : mem_if

// File: tb/tb_mem_if.sv
// Self-checking bench for mem_if. A transaction-level model (MAR/MDR values
// plus the expected ACCESS length) predicts every output; stimulus is largely
// randomized, including noise on inputs that must be ignored outside IDLE.
module tb_mem_if;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, marEn, mdrEn, rd, wr, memAck;
   logic [W-1:0] busIn, memRdata;
   logic [W-1:0] mdrOut, memAddr, memWdata;
   logic         memReq, memWe, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] mar_m = '0;
   logic [W-1:0] mdr_m = '0;

   mem_if #(.WIDTH(W), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .marEn(marEn), .mdrEn(mdrEn), .rd(rd), .wr(wr),
      .busIn(busIn), .mdrOut(mdrOut), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memReq(memReq), .memWe(memWe), .memAck(memAck),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd = 1'b0; wr = 1'b0; marEn = 1'b0; mdrEn = 1'b0; memAck = 1'b0;
   endtask

   // One transaction: optional same-cycle loads, then rd/wr with 'waits'
   // wait cycles before memAck. rd_i=wr_i=0 is a pure register load.
   task automatic run_access(input logic rd_i, input logic wr_i, input logic ld_mar,
                             input logic ld_mdr, input logic [W-1:0] bus_v,
                             input int waits, input logic [W-1:0] rdata);
      logic exp_we;
      exp_we = wr_i & ~rd_i;
      rd = rd_i; wr = wr_i; marEn = ld_mar; mdrEn = ld_mdr; busIn = bus_v;
      memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
      if (ld_mar) mar_m = bus_v;
      if (ld_mdr) mdr_m = bus_v;
      step();
      if (rd_i || wr_i) begin
         for (int i = 0; i <= waits; i++) begin
            n_checks++;
            if (memReq !== 1'b1 || memWe !== exp_we || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
               n_fail++;
               $display("FAIL access_ctrl cyc %0d: req=%b we=%b busy=%b done=%b err=%b, required req=1 we=%b busy=1 done=0 err=0",
                        i, memReq, memWe, busy, done, err, exp_we);
            end
            n_checks++;
            if (memAddr !== mar_m || memWdata !== mdr_m || mdrOut !== mdr_m) begin
               n_fail++;
               $display("FAIL access_regs cyc %0d: addr=%h wdata=%h mdr=%h, required addr=%h mdr=%h",
                        i, memAddr, memWdata, mdrOut, mar_m, mdr_m);
            end
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            marEn = 1'($urandom_range(0, 1)); mdrEn = 1'($urandom_range(0, 1));
            busIn = $urandom;
            memAck = (i == waits);
            memRdata = (i == waits) ? rdata : W'($urandom);
            step();
         end
         if (rd_i) mdr_m = rdata;
         n_checks++;
         if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || memReq !== 1'b0 || memWe !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b err=%b busy=%b req=%b we=%b, required done=1 err=0 busy=1 req=0 we=0",
                     done, err, busy, memReq, memWe);
         end
         n_checks++;
         if (mdrOut !== mdr_m || memAddr !== mar_m) begin
            n_fail++;
            $display("FAIL done_regs: mdr=%h addr=%h, required mdr=%h addr=%h", mdrOut, memAddr, mdr_m, mar_m);
         end
         // DONE cycle: every request/load/ack input here must be ignored.
         rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
         marEn = 1'($urandom_range(0, 1)); mdrEn = 1'($urandom_range(0, 1));
         busIn = $urandom; memAck = 1'($urandom_range(0, 1)); memRdata = $urandom;
         step();
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || memReq !== 1'b0 || err !== 1'b0 ||
          mdrOut !== mdr_m || memAddr !== mar_m) begin
         n_fail++;
         $display("FAIL back_to_idle: busy=%b done=%b req=%b err=%b mdr=%h addr=%h, required 0 0 0 0 mdr=%h addr=%h",
                  busy, done, memReq, err, mdrOut, memAddr, mdr_m, mar_m);
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1; rd = 1'b1; wr = 1'b1; marEn = 1'b1; mdrEn = 1'b1;
      busIn = 32'hFFFF_FFFF; memAck = 1'b1; memRdata = 32'h1234_5678;
      step();
      step();
      n_checks++;
      if (memReq !== 1'b0 || memWe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          memAddr !== 32'h0 || mdrOut !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b we=%b busy=%b done=%b err=%b addr=%h mdr=%h, required all zero",
                  memReq, memWe, busy, done, err, memAddr, mdrOut);
      end
      idle_inputs();
      reset = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || memReq !== 1'b0 || memAddr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b req=%b addr=%h, required 0 0 0", busy, memReq, memAddr);
      end
      mar_m = '0; mdr_m = '0;
   endtask

   task automatic test_directed();
      // Load MAR, zero-wait read of DEADBEEF.
      run_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 32'h0);
      run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);
      n_checks++;
      if (mdrOut !== 32'hDEAD_BEEF || memAddr !== 32'h0000_0100) begin
         n_fail++;
         $display("FAIL directed_read: mdr=%h addr=%h, required mdr=deadbeef addr=00000100", mdrOut, memAddr);
      end
      // Separate MAR/MDR loads, write with three wait cycles.
      run_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 0, 32'h0);
      run_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 0, 32'h0);
      run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3, 32'hCAFE_F00D);
      n_checks++;
      if (mdrOut !== 32'h1234_5678 || memWdata !== 32'h1234_5678 || memAddr !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL directed_write: mdr=%h wdata=%h addr=%h, required mdr=12345678 addr=00000040",
                  mdrOut, memWdata, memAddr);
      end
      // rd and wr together is a read; same-cycle MAR load is used.
      run_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1, 32'h0BAD_CAFE);
      n_checks++;
      if (mdrOut !== 32'h0BAD_CAFE || memAddr !== 32'h0000_0200) begin
         n_fail++;
         $display("FAIL rd_wr_both: mdr=%h addr=%h, required mdr=0badcafe addr=00000200", mdrOut, memAddr);
      end
   endtask

   task automatic test_mar_frozen();
      // Start a read of 0x100 and try to reload MAR with 0x200 mid-access.
      run_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 32'h0);
      rd = 1'b1; step(); rd = 1'b0;
      marEn = 1'b1; busIn = 32'h0000_0200; memAck = 1'b0;
      step();
      n_checks++;
      if (memAddr !== 32'h0000_0100 || memReq !== 1'b1) begin
         n_fail++;
         $display("FAIL mar_frozen: addr=%h req=%b, required addr=00000100 req=1", memAddr, memReq);
      end
      memAck = 1'b1; memRdata = 32'h5555_AAAA;
      step();
      marEn = 1'b0; memAck = 1'b0;
      step();
      mdr_m = 32'h5555_AAAA;
      n_checks++;
      if (memAddr !== 32'h0000_0100 || busy !== 1'b0 || mdrOut !== mdr_m) begin
         n_fail++;
         $display("FAIL mar_after_access: addr=%h busy=%b mdr=%h, required addr=00000100 busy=0 mdr=%h",
                  memAddr, busy, mdrOut, mdr_m);
      end
   endtask

   task automatic test_reset_mid_access();
      rd = 1'b1; step(); rd = 1'b0;
      memAck = 1'b0;
      step();                        // now in second ACCESS cycle
      reset = 1'b1;
      step();
      reset = 1'b0;
      mar_m = '0; mdr_m = '0;
      n_checks++;
      if (memReq !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || memAddr !== 32'h0 || mdrOut !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_access: req=%b busy=%b done=%b addr=%h mdr=%h, required all zero",
                  memReq, busy, done, memAddr, mdrOut);
      end
      memAck = 1'b1;
      step();
      memAck = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_done_after_reset: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_timeout();
      run_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0777, 0, 32'h0);
      rd = 1'b1; memAck = 1'b0; step(); rd = 1'b0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (busy !== 1'b1 || memReq !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_wait cyc %0d: busy=%b req=%b done=%b, required 1 1 0", i, busy, memReq, done);
         end
         memRdata = $urandom;
         step();
      end
      n_checks++;
      if (done !== 1'b1 || err !== 1'b1 || mdrOut !== mdr_m) begin
         n_fail++;
         $display("FAIL timeout_abort: done=%b err=%b mdr=%h, required done=1 err=1 mdr=%h", done, err, mdrOut, mdr_m);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: busy=%b err=%b done=%b, required 0 0 0", busy, err, done);
      end
`else
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (busy !== 1'b1 || memReq !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_forever cyc %0d: busy=%b req=%b done=%b err=%b, required 1 1 0 0",
                     i, busy, memReq, done, err);
         end
         memRdata = $urandom;
         step();
      end
      reset = 1'b1; step(); reset = 1'b0;
      mar_m = '0; mdr_m = '0;
      n_checks++;
      if (busy !== 1'b0 || memReq !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_recover: busy=%b req=%b, required 0 0", busy, memReq);
      end
`endif
   endtask

   task automatic test_random();
      logic r, w, lm, ld;
      for (int t = 0; t < 40; t++) begin
         r  = 1'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         lm = 1'($urandom_range(0, 1));
         ld = 1'($urandom_range(0, 1));
         run_access(r, w, lm, ld, W'($urandom), int'($urandom_range(0, 3)), W'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      // rd held high: each access restarts only after passing through IDLE.
      for (int t = 0; t < 4; t++) begin
         run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, t, W'($urandom));
         rd = 1'b1;
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0; busIn = '0; memRdata = '0;
      idle_inputs();
      test_reset();
      test_directed();
      test_mar_frozen();
      test_reset_mid_access();
      test_timeout();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_if

// File: doc/mem_if.md
MEM_IF -- requirements
Module: mem_if

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port marEn  input  1  load MAR from busIn.
REQ-006 SHALL have port mdrEn  input  1  load MDR from busIn.
REQ-007 SHALL have port rd  input  1  start memory read.
REQ-008 SHALL have port wr  input  1  start memory write.
REQ-009 SHALL have port busIn  input  WIDTH  datapath value for MAR/MDR.
REQ-010 SHALL have port mdrOut  output  WIDTH  MDR contents.
REQ-011 SHALL have port memAddr  output  WIDTH  MAR contents.
REQ-012 SHALL have port memWdata  output  WIDTH  MDR contents.
REQ-013 SHALL have port memRdata  input  WIDTH  read data from memory.
REQ-014 SHALL have port memReq  output  1  request strobe, high throughout ACCESS.
REQ-015 SHALL have port memWe  output  1  write qualifier, valid while memReq high.
REQ-016 SHALL have port memAck  input  1  memory completion, sampled only in ACCESS.
REQ-017 SHALL have port busy  output  1  high in ACCESS and DONE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse to controller.
REQ-019 SHALL have port err  output  1  timeout flag, pulses with done.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-021 IDLE: rd or wr SHALL move to ACCESS next edge; rd and wr together SHALL be a read.
REQ-022 IDLE: marEn/mdrEn SHALL load MAR/MDR; same-cycle load plus rd/wr SHALL use the newly loaded value.
REQ-023 ACCESS: memReq=1, memWe=latched op; memAck sampled high SHALL move to DONE; a read SHALL latch memRdata into MDR on that edge.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 Latency: rd/wr sampled at edge N, zero-wait memAck -> done high cycle N+2; each wait cycle adds one.
REQ-026 rd, wr, marEn, mdrEn SHALL be ignored outside IDLE; MAR/MDR stable while busy.
REQ-027 memAck outside ACCESS SHALL be ignored; a write SHALL never modify MDR.
REQ-028 rd/wr held high through DONE SHALL start a new access only when re-sampled in IDLE.

Reset
REQ-029 reset high at an edge SHALL force IDLE, MAR=0, MDR=0, memReq=0, memWe=0, busy=0, done=0, err=0, timer=0, with priority over all inputs.
REQ-030 reset mid-ACCESS SHALL drop memReq next edge with no done pulse.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; reaching TIMEOUT without memAck SHALL go to DONE with done=1 and err=1, MDR unchanged.
REQ-032 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely and err SHALL be constant 0.

Structure
REQ-033 Package cpu_pkg SHALL hold the mem_if state enumeration and default WIDTH constant.
REQ-034 Timeout counter SHALL be sub-module mem_if_timer (clear, enable, expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-035 busIn=0x100 marEn, then rd, memAck on first ACCESS cycle with memRdata=0xDEADBEEF -> memAddr=0x100, done two cycles after rd, mdrOut=0xDEADBEEF.
REQ-036 marEn+mdrEn in separate cycles (0x40, 0x12345678), wr, memAck after 3 wait cycles -> memWe=1, memWdata=0x12345678, done at N+5, MDR unchanged.
REQ-037 rd and wr asserted together -> memWe=0, read performed.
REQ-038 marEn busIn=0x200 during ACCESS of access to 0x100 -> memAddr stays 0x100 until IDLE.
REQ-039 reset asserted on 2nd ACCESS cycle -> memReq=0, busy=0 next edge, no done.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT=4, no memAck -> done=1 and err=1 after 4 ACCESS cycles; without macro, busy remains high.
